qspi_rom_arbiter: RTL
=====================

QSPI_ROM_ARBITER -- requirements
Module: qspi_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, ROM byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_address  input  ADDR_WIDTH  instruction-fetch address.
REQ-006 SHALL have port i_req  input  1  instruction-fetch request (level).
REQ-007 SHALL have port i_ack  output  1  instruction-fetch acknowledge.
REQ-008 SHALL have port i_data  output  DATA_WIDTH  instruction-fetch read data.
REQ-009 SHALL have ports d_address, d_req, d_ack and d_data, matching REQ-005 to REQ-008, for the data-read port.
REQ-010 SHALL have port rom_address  output  ADDR_WIDTH  address to the QSPI ROM controller.
REQ-011 SHALL have port rom_req  output  1  request to the controller.
REQ-012 SHALL have port rom_ack  input  1  controller acknowledge.
REQ-013 SHALL have port rom_data  input  DATA_WIDTH  controller read data.

Function
REQ-014 SHALL use a four-phase handshake on every port:
- requester raises req with the address held stable;
- responder raises ack with data valid;
- requester drops req;
- responder drops ack.
REQ-015 SHALL implement a state machine with four states:
- IDLE
- ROM_WAIT (rom_req=1, waiting for rom_ack=1)
- ROM_REL (rom_req=0, waiting for rom_ack=0)
- DONE (port ack=1, waiting for port req=0)
REQ-016 In IDLE, a pending request (req=1, ack=0) SHALL be granted, rom_address/rom_req registered, and the state SHALL move to ROM_WAIT on the next edge.
REQ-017 Simultaneous pending requests SHALL be resolved round-robin: the port not served last wins; after reset the instruction port wins.
REQ-018 On rom_ack=1 in ROM_WAIT, the arbiter SHALL capture rom_data into the granted port's data register, drop rom_req and enter ROM_REL.
REQ-019 On rom_ack=0 in ROM_REL, the arbiter SHALL raise the granted port's ack and enter DONE; if the granted port's req is already 0, it SHALL discard the data, leave ack low and return to IDLE.
REQ-020 In DONE, the arbiter SHALL drop ack once the port's req=0 is seen, then return to IDLE; a new grant SHALL NOT start in the cycle ack falls.
REQ-021 A grant SHALL never be preempted; the non-granted port's req SHALL be held pending without a timeout.
REQ-022 Port data outputs SHALL hold their last value until the next completion for that port.
REQ-023 rom_address SHALL stay stable from the rise of rom_req until rom_ack falls.

Reset
REQ-024 While nreset=0, the arbiter SHALL drive i_ack=0, d_ack=0, rom_req=0, rom_address=0, i_data=0 and d_data=0, set state=IDLE, set the round-robin pointer to the instruction port and clear cache valid bits.
REQ-025 Reset asserted mid-transaction SHALL abort that transaction without a spurious ack; the controller shares nreset and resets jointly.

Configuration
REQ-026 With QSPI_ARB_CACHE_EN defined, each port SHALL hold a one-entry buffer (tag=ADDR_WIDTH, data, valid) loaded on every completion for that port.
REQ-027 With QSPI_ARB_CACHE_EN defined, a pending request whose address equals the valid tag SHALL be acked from the buffer in IDLE on the next edge, entering DONE without rom_req.
REQ-028 A buffer hit SHALL NOT update the round-robin pointer; the ROM is read-only, so no invalidation other than reset is required.
REQ-029 Without QSPI_ARB_CACHE_EN, every request SHALL access the ROM and no buffer logic SHALL be present.

Structure
REQ-030 State encodings and default widths SHALL live in shared package qspi_rom_pkg.
REQ-031 The optional buffer SHALL be sub-module qspi_rom_line_buf, instantiated once per port under the macro.

Verification
REQ-032 Single fetch: i_req=1 at i_address=0x000100 with ROM model returning 0xDEADBEEF -> one rom_req pulse at 0x000100, then i_ack=1 with i_data=0xDEADBEEF; d_ack stays 0.
REQ-033 Contention: i_req and d_req rise in the same cycle after reset -> instruction port served first, data second; a repeated collision serves data first.
REQ-034 Late drop: d_req falls while ROM_WAIT is active -> ROM cycle completes, d_ack never rises, state returns to IDLE, and the next i_req is served normally.
REQ-035 Reset mid-transaction: nreset=0 during ROM_WAIT -> all acks and rom_req are 0 on the next edge; a fresh fetch after reset returns correct data.
REQ-036 With QSPI_ARB_CACHE_EN: two consecutive i_req at 0x000200 -> one ROM access, second i_ack 1 cycle after req, identical data.
REQ-037 Without QSPI_ARB_CACHE_EN: two consecutive i_req at 0x000200 -> two ROM accesses.

Source files
------------

// File: rtl/qspi_rom_pkg.sv
// qspi_rom_pkg
// Shared definitions for the QSPI ROM arbiter slice: default bus widths,
// arbiter state encodings, port identifiers and the round-robin pick helper.
// Optional build macro used by this slice: QSPI_ARB_CACHE_EN (per-port
// one-entry read buffer).

package qspi_rom_pkg;

    localparam int QSPI_ADDR_WIDTH = 24;
    localparam int QSPI_DATA_WIDTH = 32;

    // Arbiter state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ROM_WAIT = 2'd1;
    localparam logic [1:0] ST_ROM_REL  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Requester identifiers, also used as the round-robin pointer value
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Chooses which pending port to serve. On a collision the port named by
    // the priority pointer wins; otherwise whichever port is pending.
    function automatic logic pick_port(input logic i_pend, input logic d_pend,
                                       input logic prio);
        if (i_pend && d_pend) begin
            return prio;
        end else if (d_pend) begin
            return PORT_D;
        end else begin
            return PORT_I;
        end
    endfunction

endpackage

// File: rtl/qspi_rom_line_buf.sv
// qspi_rom_line_buf
// One-entry read buffer for a single requester port of the QSPI ROM arbiter.
// Holds the last completed ROM word together with its address tag; the ROM
// is read-only so the entry stays valid until reset.
// Only instantiated when QSPI_ARB_CACHE_EN is defined.
// Ports:
//   clk, nreset  - clock, synchronous active-low reset
//   load_i       - write tag_i/data_i into the entry and mark it valid
//   tag_i        - address of the word being loaded
//   data_i       - word being loaded
//   addr_i       - lookup address (the port's current request address)
//   hit_o        - entry valid and tag equals addr_i
//   data_o       - buffered word

module qspi_rom_line_buf
    import qspi_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = QSPI_ADDR_WIDTH,
    parameter int DATA_WIDTH = QSPI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] tag_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Entry storage; only a reset invalidates it
    always_ff @(posedge clk) begin
        if (!nreset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            data_q  <= data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/qspi_rom_arbiter.sv
// qspi_rom_arbiter
// Arbitrates an instruction-fetch port and a data-read port onto a single
// QSPI ROM controller. All three interfaces use a four-phase req/ack
// handshake. Collisions are resolved round-robin (instruction port first
// after reset); a grant always runs to completion.
// Optional build macro: QSPI_ARB_CACHE_EN adds a one-entry read buffer per
// port (qspi_rom_line_buf) that can answer a repeated address without a ROM
// access.
// Ports:
//   clk, nreset                       - clock, synchronous active-low reset
//   i_address/i_req/i_ack/i_data      - instruction-fetch port
//   d_address/d_req/d_ack/d_data      - data-read port
//   rom_address/rom_req/rom_ack/rom_data - QSPI ROM controller side

module qspi_rom_arbiter
    import qspi_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = QSPI_ADDR_WIDTH,
    parameter int DATA_WIDTH = QSPI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_req,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic                  d_req,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_req,
    input  logic                  rom_ack,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  prio_q, prio_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic                  rom_req_q, rom_req_d;
    logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
    logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
    logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;

    logic                  i_pend;
    logic                  d_pend;
    logic                  pick;
    logic                  gnt_req;
    logic                  pick_hit;
    logic [DATA_WIDTH-1:0] pick_hit_data;

    assign i_pend  = i_req && !i_ack_q;
    assign d_pend  = d_req && !d_ack_q;
    assign pick    = pick_port(i_pend, d_pend, prio_q);
    assign gnt_req = (grant_q == PORT_D) ? d_req : i_req;

`ifdef QSPI_ARB_CACHE_EN
    logic                  rom_done;
    logic                  i_hit;
    logic                  d_hit;
    logic [DATA_WIDTH-1:0] i_buf_data;
    logic [DATA_WIDTH-1:0] d_buf_data;

    // A ROM completion is the ROM_REL exit that actually raises the port ack
    assign rom_done = (state_q == ST_ROM_REL) && !rom_ack;

    qspi_rom_line_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_i_buf (
        .clk    (clk),
        .nreset (nreset),
        .load_i (rom_done && (grant_q == PORT_I) && i_req),
        .tag_i  (rom_address_q),
        .data_i (cap_q),
        .addr_i (i_address),
        .hit_o  (i_hit),
        .data_o (i_buf_data)
    );

    qspi_rom_line_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_d_buf (
        .clk    (clk),
        .nreset (nreset),
        .load_i (rom_done && (grant_q == PORT_D) && d_req),
        .tag_i  (rom_address_q),
        .data_i (cap_q),
        .addr_i (d_address),
        .hit_o  (d_hit),
        .data_o (d_buf_data)
    );

    assign pick_hit      = (pick == PORT_D) ? d_hit : i_hit;
    assign pick_hit_data = (pick == PORT_D) ? d_buf_data : i_buf_data;
`else
    assign pick_hit      = 1'b0;
    assign pick_hit_data = '0;
`endif

    // Next-state logic. ROM data goes into a private capture register first
    // and is only copied to the port output once the port is still asking
    // for it, so a dropped request never disturbs the port's last data.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        prio_d        = prio_q;
        i_ack_d       = i_ack_q;
        d_ack_d       = d_ack_q;
        rom_req_d     = rom_req_q;
        rom_address_d = rom_address_q;
        i_data_d      = i_data_q;
        d_data_d      = d_data_q;
        cap_d         = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_pend || d_pend) begin
                    grant_d = pick;
                    if (pick_hit) begin
                        // Buffer hit: answer directly, pointer untouched
                        if (pick == PORT_D) begin
                            d_ack_d  = 1'b1;
                            d_data_d = pick_hit_data;
                        end else begin
                            i_ack_d  = 1'b1;
                            i_data_d = pick_hit_data;
                        end
                        state_d = ST_DONE;
                    end else begin
                        rom_req_d     = 1'b1;
                        rom_address_d = (pick == PORT_D) ? d_address : i_address;
                        prio_d        = ~pick;
                        state_d       = ST_ROM_WAIT;
                    end
                end
            end
            ST_ROM_WAIT: begin
                if (rom_ack) begin
                    cap_d     = rom_data;
                    rom_req_d = 1'b0;
                    state_d   = ST_ROM_REL;
                end
            end
            ST_ROM_REL: begin
                if (!rom_ack) begin
                    if (gnt_req) begin
                        if (grant_q == PORT_D) begin
                            d_ack_d  = 1'b1;
                            d_data_d = cap_q;
                        end else begin
                            i_ack_d  = 1'b1;
                            i_data_d = cap_q;
                        end
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!gnt_req) begin
                    i_ack_d = 1'b0;
                    d_ack_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset also aborts any ROM transaction in flight
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            grant_q       <= PORT_I;
            prio_q        <= PORT_I;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            rom_req_q     <= 1'b0;
            rom_address_q <= '0;
            i_data_q      <= '0;
            d_data_q      <= '0;
            cap_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            prio_q        <= prio_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            rom_req_q     <= rom_req_d;
            rom_address_q <= rom_address_d;
            i_data_q      <= i_data_d;
            d_data_q      <= d_data_d;
            cap_q         <= cap_d;
        end
    end

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_data      = i_data_q;
    assign d_data      = d_data_q;
    assign rom_req     = rom_req_q;
    assign rom_address = rom_address_q;

endmodule
